secuenciador_lectura_rtc: RTL and testbench

Upstream feeder of the VGA display interface. Once per frame, on a start pulse issued at the beginning of vertical blanking, it reads the 11 time/timer registers of the external multiplexed-bus RTC and converts each BCD byte to binary. It then streams the results, each with a one-cycle valid strobe, into the display's `datoRTC` / `inicioSecuencia` inputs. A fixed number of zero-valued dummy bytes precede the data, giving the display its pipeline delay slots.

---
 rtl/secuenciador_lectura_rtc.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_secuenciador_lectura_rtc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_lectura_rtc.sv
// secuenciador_lectura_rtc
// Once per frame, reads the 11 time/timer registers of a multiplexed-bus RTC,
// converts each BCD byte to binary and streams the results (preceded by
// N_DUMMY zero bytes) with a one-cycle valid strobe to the VGA display.
// Optional build macro: RTC_TRANSFER_EN -- issues a 0xF0 transfer command
// before the first address write so the RTC latches its time registers.
module secuenciador_lectura_rtc #(
   parameter int unsigned T_PULSE = 4,
   parameter int unsigned T_GAP   = 2,
   parameter int unsigned N_DUMMY = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d,
   output logic [7:0] dato,
   output logic       dato_valid,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_DUMMY    = 4'd1;
`ifdef RTC_TRANSFER_EN
   localparam logic [3:0] S_CMD_WR   = 4'd2;
   localparam logic [3:0] S_CMD_GAP  = 4'd3;
`endif
   localparam logic [3:0] S_ADDR_WR  = 4'd4;
   localparam logic [3:0] S_ADDR_GAP = 4'd5;
   localparam logic [3:0] S_DATA_RD  = 4'd6;
   localparam logic [3:0] S_DATA_GAP = 4'd7;
   localparam logic [3:0] S_EMIT     = 4'd8;
   localparam logic [3:0] S_DONE     = 4'd9;

   // First bus phase after the dummy bytes (or straight after start).
`ifdef RTC_TRANSFER_EN
   localparam logic [3:0] S_FIRST    = S_CMD_WR;
`else
   localparam logic [3:0] S_FIRST    = S_ADDR_WR;
`endif

   localparam logic [3:0] PULSE_LAST = 4'(T_PULSE - 1);
   localparam logic [3:0] GAP_LAST   = 4'(T_GAP - 1);
   localparam logic [3:0] DUMMY_LAST = 4'(N_DUMMY - 1);
   localparam logic [3:0] IDX_LAST   = 4'd10;
   localparam logic [7:0] CMD_XFER   = 8'hF0;

   logic [3:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] raw_q;

   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       a_d_q, a_d_d;
   logic       ad_oe_q, ad_oe_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic [7:0] dato_q, dato_d;
   logic       dato_valid_q, dato_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   // RTC register address table, in read order.
   function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
      logic [7:0] addr;
      case (idx)
         4'd0:    addr = 8'h21;
         4'd1:    addr = 8'h22;
         4'd2:    addr = 8'h23;
         4'd3:    addr = 8'h24;
         4'd4:    addr = 8'h25;
         4'd5:    addr = 8'h26;
         4'd6:    addr = 8'h27;
         4'd7:    addr = 8'h28;
         4'd8:    addr = 8'h41;
         4'd9:    addr = 8'h42;
         4'd10:   addr = 8'h43;
         default: addr = 8'h00;
      endcase
      return addr;
   endfunction

   // Packed BCD to binary; any nibble above 9 flags the byte as 0xFF.
   function automatic logic [7:0] bcd_to_bin(input logic [7:0] bcd);
      logic [6:0] bin;
      if ((bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9)) begin
         return 8'hFF;
      end
      bin = 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
      return {1'b0, bin};
   endfunction

   // Sequencer next state: phase counter, register index and state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 4'd1;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 4'd0;
            if (start) begin
               state_d = (N_DUMMY != 0) ? S_DUMMY : S_FIRST;
            end
         end
         S_DUMMY: begin
            if (cnt_q == DUMMY_LAST) begin
               state_d = S_FIRST;
               cnt_d   = 4'd0;
            end
         end
`ifdef RTC_TRANSFER_EN
         S_CMD_WR: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = S_CMD_GAP;
               cnt_d   = 4'd0;
            end
         end
         S_CMD_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_ADDR_WR;
               cnt_d   = 4'd0;
            end
         end
`endif
         S_ADDR_WR: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = S_ADDR_GAP;
               cnt_d   = 4'd0;
            end
         end
         S_ADDR_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_DATA_RD;
               cnt_d   = 4'd0;
            end
         end
         S_DATA_RD: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = S_DATA_GAP;
               cnt_d   = 4'd0;
            end
         end
         S_DATA_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_EMIT;
               cnt_d   = 4'd0;
            end
         end
         S_EMIT: begin
            cnt_d = 4'd0;
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = S_ADDR_WR;
            end
         end
         S_DONE: begin
            cnt_d   = 4'd0;
            idx_d   = 4'd0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            idx_d   = 4'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so every output is a flop that
   // lines up exactly with the state it belongs to.
   always_comb begin
      cs_n_d       = 1'b1;
      rd_n_d       = 1'b1;
      wr_n_d       = 1'b1;
      a_d_d        = 1'b0;
      ad_oe_d      = 1'b0;
      ad_out_d     = ad_out_q;
      dato_d       = dato_q;
      dato_valid_d = 1'b0;
      busy_d       = 1'b1;
      done_d       = 1'b0;
      case (state_d)
         S_IDLE: busy_d = 1'b0;
         S_DUMMY: begin
            dato_d       = 8'd0;
            dato_valid_d = 1'b1;
         end
`ifdef RTC_TRANSFER_EN
         S_CMD_WR: begin
            cs_n_d   = 1'b0;
            wr_n_d   = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = CMD_XFER;
         end
         S_CMD_GAP: ad_oe_d = 1'b1;
`endif
         S_ADDR_WR: begin
            cs_n_d   = 1'b0;
            wr_n_d   = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = rtc_addr(idx_d);
         end
         S_ADDR_GAP: ad_oe_d = 1'b1;
         S_DATA_RD: begin
            cs_n_d = 1'b0;
            rd_n_d = 1'b0;
            a_d_d  = 1'b1;
         end
         S_DATA_GAP: busy_d = 1'b1;
         S_EMIT: begin
            dato_d       = bcd_to_bin(raw_q);
            dato_valid_d = 1'b1;
         end
         S_DONE: begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: busy_d = 1'b0;
      endcase
   end

   // Control state and registered outputs; reset drives the bus idle at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         idx_q        <= 4'd0;
         cs_n_q       <= 1'b1;
         rd_n_q       <= 1'b1;
         wr_n_q       <= 1'b1;
         a_d_q        <= 1'b0;
         ad_oe_q      <= 1'b0;
         ad_out_q     <= 8'h00;
         dato_q       <= 8'h00;
         dato_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         cs_n_q       <= cs_n_d;
         rd_n_q       <= rd_n_d;
         wr_n_q       <= wr_n_d;
         a_d_q        <= a_d_d;
         ad_oe_q      <= ad_oe_d;
         ad_out_q     <= ad_out_d;
         dato_q       <= dato_d;
         dato_valid_q <= dato_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Capture the RTC byte on the edge that closes the read strobe.
   always_ff @(posedge clk) begin
      if ((state_q == S_DATA_RD) && (cnt_q == PULSE_LAST)) begin
         raw_q <= ad_in;
      end
   end

   assign cs_n       = cs_n_q;
   assign rd_n       = rd_n_q;
   assign wr_n       = wr_n_q;
   assign a_d        = a_d_q;
   assign ad_oe      = ad_oe_q;
   assign ad_out     = ad_out_q;
   assign dato       = dato_q;
   assign dato_valid = dato_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_secuenciador_lectura_rtc.sv
// Testbench for secuenciador_lectura_rtc: RTC bus model plus a timeline
// reference model of dummy bytes, address writes, converted data and done.
module tb_secuenciador_lectura_rtc;

   localparam int TP = 4;
   localparam int TG = 2;
   localparam int ND = 4;
`ifdef RTC_TRANSFER_EN
   localparam int SH  = TP + TG;
   localparam bit CMD = 1'b1;
`else
   localparam int SH  = 0;
   localparam bit CMD = 1'b0;
`endif
   localparam int P = 2 * TP + 2 * TG + 1;
   localparam logic [23:0] RST_V = 24'hE00000;

   typedef struct {
      int         off;
      logic [10:0] v;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] ad_in;
   logic [7:0] ad_out;
   logic       ad_oe, cs_n, rd_n, wr_n, a_d;
   logic [7:0] dato;
   logic       dato_valid, busy, done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int k0    = 0;

   logic [7:0] regs [0:10];
   logic [7:0] addrs [0:10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
   logic [7:0] last_addr = 8'h00;

   ev_t vq[$];
   ev_t wq[$];
   int  dq[$];
   int  rdc = 0;
   int  ovl = 0;
   int  bc  = 0;

   secuenciador_lectura_rtc #(.T_PULSE(TP), .T_GAP(TG), .N_DUMMY(ND)) dut (
      .clk(clk), .reset(reset), .start(start), .ad_in(ad_in),
      .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
      .a_d(a_d), .dato(dato), .dato_valid(dato_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RTC model: latch the address written, return its register while read.
   always @(posedge clk) begin
      if (!cs_n && !wr_n && !a_d) last_addr <= ad_out;
   end

   always_comb begin
      ad_in = 8'hEE;
      if (!cs_n && !rd_n) begin
         if (last_addr >= 8'h21 && last_addr <= 8'h28)
            ad_in = regs[last_addr[3:0] - 4'd1];
         else if (last_addr >= 8'h41 && last_addr <= 8'h43)
            ad_in = regs[4'd7 + last_addr[3:0]];
      end
   end

   // Event recorder, sampling on the falling edge.
   always @(negedge clk) begin : rec
      int off;
      off = cyc - k0 + 1;
      if (dato_valid) vq.push_back('{off, {3'b000, dato}});
      if (done) dq.push_back(off);
      if (!wr_n) wq.push_back('{off, {cs_n, ad_oe, a_d, ad_out}});
      if (!rd_n) rdc++;
      if (!rd_n && !wr_n) ovl++;
      if (busy) bc++;
   end

   function automatic logic [23:0] outv();
      return {cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, dato, dato_valid, busy, done};
   endfunction

   function automatic logic [7:0] exp_conv(input int v);
      int t, u;
      t = v / 16;
      u = v % 16;
      if (t > 9 || u > 9) return 8'hFF;
      return 8'(t * 10 + u);
   endfunction

   task automatic set_std_regs();
      regs = '{8'h59, 8'h07, 8'h23, 8'h31, 8'h12, 8'h17, 8'h05, 8'h52,
               8'h30, 8'h45, 8'h01};
   endtask

   task automatic run_sequence(input string name, input int collide);
      int bv, bw, bd, bb, br, bo, off, expd;
      bit got_done;
      ev_t ev[$];
      ev_t ew[$];
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      k0 = cyc;
      bv = vq.size(); bw = wq.size(); bd = dq.size();
      bb = bc; br = rdc; bo = ovl;
      start = 1'b0;
      got_done = 1'b0;
      for (int t = 0; t < 600 && !got_done; t++) begin
         @(negedge clk);
         off = cyc - k0 + 1;
         start = (collide > 0 && off == collide);
         if (dq.size() > bd) got_done = 1'b1;
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (!got_done) begin
         bad++;
         $display("FAIL %s timeout: done not seen within 600 cycles", name);
      end
      for (int i = 0; i < ND; i++) ev.push_back('{i + 1, 11'h000});
      for (int i = 0; i < 11; i++)
         ev.push_back('{ND + SH + P * (i + 1), {3'b000, exp_conv(int'(regs[i]))}});
      if (CMD)
         for (int j = 0; j < TP; j++) ew.push_back('{ND + 1 + j, {3'b010, 8'hF0}});
      for (int i = 0; i < 11; i++)
         for (int j = 0; j < TP; j++)
            ew.push_back('{ND + SH + P * i + 1 + j, {3'b010, addrs[i]}});
      expd = ND + SH + 11 * P + 1;

      total++;
      if (vq.size() - bv != ev.size()) begin
         bad++;
         $display("FAIL %s valid_count: got %0d want %0d", name, vq.size() - bv, ev.size());
      end
      for (int i = 0; i < ev.size() && bv + i < vq.size(); i++) begin
         total++;
         if (vq[bv + i].off !== ev[i].off || vq[bv + i].v[7:0] !== ev[i].v[7:0]) begin
            bad++;
            $display("FAIL %s byte%0d: got k+%0d 0x%02h want k+%0d 0x%02h", name, i,
                     vq[bv + i].off, vq[bv + i].v[7:0], ev[i].off, ev[i].v[7:0]);
         end
      end
      total++;
      if (wq.size() - bw != ew.size()) begin
         bad++;
         $display("FAIL %s write_cycles: got %0d want %0d", name, wq.size() - bw, ew.size());
      end
      for (int i = 0; i < ew.size() && bw + i < wq.size(); i++) begin
         total++;
         if (wq[bw + i].off !== ew[i].off || wq[bw + i].v !== ew[i].v) begin
            bad++;
            $display("FAIL %s write%0d: got k+%0d {cs,oe,ad,bus}=0x%03h want k+%0d 0x%03h",
                     name, i, wq[bw + i].off, wq[bw + i].v, ew[i].off, ew[i].v);
         end
      end
      total++;
      if (dq.size() - bd != 1) begin
         bad++;
         $display("FAIL %s done_count: got %0d want 1", name, dq.size() - bd);
      end else if (dq[bd] != expd) begin
         bad++;
         $display("FAIL %s done_time: got k+%0d want k+%0d", name, dq[bd], expd);
      end
      total++;
      if (bc - bb != expd - 1) begin
         bad++;
         $display("FAIL %s busy_cycles: got %0d want %0d", name, bc - bb, expd - 1);
      end
      total++;
      if (rdc - br != 11 * TP || ovl != bo) begin
         bad++;
         $display("FAIL %s read_strobe: got rd=%0d overlap=%0d want rd=%0d overlap=0",
                  name, rdc - br, ovl - bo, 11 * TP);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      total++;
      if (outv() !== RST_V) begin
         bad++;
         $display("FAIL reset_values: got 0x%06h want 0x%06h", outv(), RST_V);
      end
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (outv() !== RST_V) begin
            bad++;
            $display("FAIL idle_hold cycle%0d: got 0x%06h want 0x%06h", i, outv(), RST_V);
         end
      end
   endtask

   task automatic test_full_sequence();
      set_std_regs();
      run_sequence("full", 0);
   endtask

   task automatic test_invalid_bcd();
      set_std_regs();
      regs[1] = 8'h5A;
      run_sequence("invalid_bcd", 0);
   endtask

   task automatic test_busy_collision();
      set_std_regs();
      run_sequence("collision", 50);
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 11; i++) begin
            if ($urandom_range(0, 3) == 0)
               regs[i] = 8'($urandom);
            else
               regs[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
         run_sequence("random", (r == 1) ? int'($urandom_range(20, 140)) : 0);
      end
   endtask

   task automatic test_back_to_back();
      set_std_regs();
      run_sequence("b2b_first", 0);
      regs[0] = 8'h00;
      regs[10] = 8'h99;
      run_sequence("b2b_second", 0);
   endtask

   task automatic test_reset_mid_read();
      int bv, bv2, bd2;
      bit found;
      set_std_regs();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      k0 = cyc;
      bv = vq.size();
      start = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 300 && !found; t++) begin
         @(negedge clk);
         if (!rd_n && last_addr == 8'h24) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL mid_reset timeout: read of register 3 not seen");
      end
      reset = 1'b0;
      #1;
      total++;
      if ({cs_n, rd_n, wr_n, dato_valid, busy, done} !== 6'b111000) begin
         bad++;
         $display("FAIL mid_reset strobes: got %b want 111000",
                  {cs_n, rd_n, wr_n, dato_valid, busy, done});
      end
      total++;
      if (vq.size() - bv != ND + 3) begin
         bad++;
         $display("FAIL mid_reset pulses_before: got %0d want %0d", vq.size() - bv, ND + 3);
      end
      bv2 = vq.size();
      bd2 = dq.size();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (60) @(negedge clk);
      total++;
      if (vq.size() != bv2 || dq.size() != bd2 || busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset no_resume: got valid=%0d done=%0d busy=%b want 0 0 0",
                  vq.size() - bv2, dq.size() - bd2, busy);
      end
      run_sequence("after_reset", 0);
   endtask

   initial begin
      set_std_regs();
      test_reset();
      test_full_sequence();
      test_invalid_bcd();
      test_busy_collision();
      test_random();
      test_back_to_back();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
